// File: rtl/port_io.sv
// Port I/O responder: buffers CPU port writes into a TX FIFO drained by a four-phase
// pin handshake, and captures inbound strobed data for CPU reads.
module port_io #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [WIDTH-1:0]           DATA_IN,
    input  logic                       PDR_EN,
    input  logic                       PORT_EN,
    input  logic                       PORT_RD,
    output logic [WIDTH-1:0]           DATA_OUT,
    output logic                       DATA_OE,
    output logic [WIDTH-1:0]           PIO_DOUT,
    output logic                       PIO_VALID,
    input  logic                       PIO_ACK,
    input  logic [WIDTH-1:0]           PIO_DIN,
    input  logic                       PIO_STB,
    output logic [$clog2(DEPTH):0]     TX_LEVEL,
    output logic                       TX_FULL,
    output logic                       RX_FULL,
    output logic                       TX_OVF,
    output logic                       RX_OVF
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, SEND, RELEASE} tx_state_t;

    tx_state_t        state;
    logic [WIDTH-1:0] pdr;
    logic [WIDTH-1:0] hold;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic             cpu_wr;
    logic             cpu_rd;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] wr_word;
    logic [LVL_W-1:0] level_next;

    always_comb begin
        cpu_wr     = PORT_EN & ~PORT_RD;
        cpu_rd     = PORT_EN & PORT_RD;
        wr_word    = PDR_EN ? DATA_IN : pdr;
        push       = cpu_wr & ~TX_FULL;
        pop        = (state == IDLE) && (TX_LEVEL != '0);
        level_next = TX_LEVEL + LVL_W'(push) - LVL_W'(pop);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pdr <= '0;
        end else if (PDR_EN) begin
            pdr <= DATA_IN;
        end
    end

    // Storage needs no reset: contents are only reachable through the pointers.
    always_ff @(posedge CLK) begin
        if (!RST && push) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    // FIFO bookkeeping and outbound four-phase handshake.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            TX_LEVEL  <= '0;
            TX_FULL   <= 1'b0;
            TX_OVF    <= 1'b0;
            PIO_DOUT  <= '0;
            PIO_VALID <= 1'b0;
            state     <= IDLE;
        end else begin
            TX_LEVEL <= level_next;
            TX_FULL  <= (level_next == LVL_W'(DEPTH));
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (cpu_wr && TX_FULL) begin
                TX_OVF <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        PIO_DOUT  <= mem[rd_ptr];
                        PIO_VALID <= 1'b1;
                        rd_ptr    <= rd_ptr + PTR_W'(1);
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (PIO_ACK) begin
                        PIO_VALID <= 1'b0;
                        state     <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!PIO_ACK) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Inbound capture and CPU read; a read frees the slot for a same-cycle strobe.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hold     <= '0;
            RX_FULL  <= 1'b0;
            RX_OVF   <= 1'b0;
            DATA_OUT <= '0;
            DATA_OE  <= 1'b0;
        end else begin
            DATA_OE <= cpu_rd;
            if (cpu_rd) begin
                DATA_OUT <= RX_FULL ? hold : '0;
            end
            if (PIO_STB && (!RX_FULL || cpu_rd)) begin
                hold    <= PIO_DIN;
                RX_FULL <= 1'b1;
            end else if (cpu_rd) begin
                RX_FULL <= 1'b0;
            end
            if (PIO_STB && RX_FULL && !cpu_rd) begin
                RX_OVF <= 1'b1;
            end
        end
    end

endmodule

// File: doc/port_io.md
# port_io

Port I/O responder for the RISC-V datapath. It is the slave end of the sequence controller's port strobes: it answers PDR_EN, PORT_EN and PORT_RD by buffering CPU writes into a TX FIFO and returning captured input data on reads. It also runs four-phase handshakes with an external device on the pin side. It sits between the CPU data bus and the chip-level port pins.

## Interface
- WIDTH, 8: data width of the CPU bus and the port.
- DEPTH, 4: TX FIFO entries. Must be a power of 2 and at least 2.

- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous and active-high.
- DATA_IN  in  WIDTH  CPU write data (ALU/accumulator bus).
- PDR_EN  in  1  load DATA_IN into the port data register (PDR).
- PORT_EN  in  1  one-cycle port transfer strobe.
- PORT_RD  in  1  transfer direction, qualified by PORT_EN: 1 = read from port, 0 = write to port.
- DATA_OUT  out  WIDTH  read data to the CPU bus.
- DATA_OE  out  1  DATA_OUT valid; one-cycle pulse.
- PIO_DOUT  out  WIDTH  outbound port data.
- PIO_VALID  out  1  outbound handshake request.
- PIO_ACK  in  1  outbound handshake acknowledge.
- PIO_DIN  in  WIDTH  inbound port data.
- PIO_STB  in  1  inbound one-cycle strobe; PIO_DIN is valid in the same cycle.
- TX_LEVEL  out  $clog2(DEPTH)+1  TX FIFO occupancy.
- TX_FULL  out  1  TX_LEVEL == DEPTH.
- RX_FULL  out  1  RX holding register occupied.
- TX_OVF  out  1  sticky: a CPU write was dropped because the FIFO was full.
- RX_OVF  out  1  sticky: an inbound strobe was dropped because the holding register was full.

## Operation
- **PDR write:** when PDR_EN=1, PDR <= DATA_IN.
- **CPU write** (PORT_EN=1, PORT_RD=0):
  - The written word is PDR. If PDR_EN is asserted in the same cycle, the word is DATA_IN instead (bypass).
  - If the FIFO is not full, the word is pushed.
  - If the FIFO is full, the word is dropped, TX_OVF <= 1 and the FIFO is unchanged.
- **TX FIFO:** circular buffer with read and write pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH. Push and pop in the same cycle leave TX_LEVEL unchanged. A push while full is never accepted, even if a pop occurs in the same cycle.
- **TX FSM** (four-phase handshake):
  - IDLE: if TX_LEVEL>0, pop the head into PIO_DOUT, set PIO_VALID <= 1 and go to SEND.
  - SEND: hold PIO_DOUT and PIO_VALID. When PIO_ACK=1, set PIO_VALID <= 0 and go to RELEASE.
  - RELEASE: when PIO_ACK=0, go to IDLE.
  - PIO_DOUT keeps its last value after PIO_VALID drops.
- **RX capture:**
  - PIO_STB=1 with RX_FULL=0: holding register <= PIO_DIN, RX_FULL <= 1.
  - PIO_STB=1 with RX_FULL=1: PIO_DIN is dropped and RX_OVF <= 1, except in the simultaneous case below.
- **CPU read** (PORT_EN=1, PORT_RD=1):
  - Next cycle: DATA_OUT <= holding register if RX_FULL, else 0. DATA_OE <= 1 for exactly one cycle.
  - RX_FULL <= 0.
  - Simultaneous read and PIO_STB while full: the read returns the old value, the new value is captured, RX_FULL stays 1 and there is no overflow.
- **No-strobe behaviour:** PORT_RD is ignored when PORT_EN=0. DATA_OUT holds its value between reads.
- **Sticky flags:** TX_OVF and RX_OVF are cleared only by RST.

## Timing
- **Reset** (on the edge with RST=1):
  - PDR, DATA_OUT and PIO_DOUT = 0.
  - DATA_OE, PIO_VALID, RX_FULL, TX_OVF and RX_OVF = 0.
  - TX_LEVEL = 0, pointers = 0, TX_FULL = 0, FSM = IDLE.
  - RST has priority over every strobe in the same cycle.
- **Reset mid-handshake:** PIO_VALID drops after the reset edge, all FIFO contents are discarded, and the FSM restarts in IDLE regardless of PIO_ACK.
- **Write latency:**
  - A push on edge k raises TX_LEVEL after edge k.
  - If the FSM is IDLE, PIO_VALID=1 after edge k+1; the pop lowers TX_LEVEL on that same edge.
  - Best-case word-to-word spacing on PIO_VALID: the rising edge, plus one cycle minimum each in SEND and RELEASE, gives at least 3 cycles per word.
- **Read latency:** the PORT_EN read is sampled on edge k; DATA_OUT and DATA_OE are valid after edge k. DATA_OE drops after edge k+1 unless another read occurs.
- **RX capture latency:** RX_FULL is set after the edge that samples PIO_STB.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset:** drive RST for 2 cycles with PORT_EN=1 and PIO_STB=1 -> all outputs 0, TX_LEVEL=0, no push or capture.
- **Single write:**
  - Stimulus: PDR_EN with DATA_IN=0xA5, then PORT_EN write. Ack device responds 2 cycles after PIO_VALID.
  - Required: PIO_VALID rises one cycle after the push with PIO_DOUT=0xA5; it falls after ACK; the FSM returns to IDLE after ACK drops; TX_LEVEL goes 0 -> 1 -> 0.
- **FIFO full and overflow:**
  - Stimulus: hold PIO_ACK=0 and issue 6 writes of 0x01..0x06 with DEPTH=4.
  - Required: 0x01 presented; 0x02..0x05 fill the FIFO; TX_FULL=1; 0x06 dropped; TX_OVF=1.
  - Then release ACK cycles. Required: words 0x02..0x05 appear in order.
- **Bypass:** PDR_EN and a PORT_EN write in the same cycle with DATA_IN=0x3C and old PDR=0x11 -> 0x3C pushed and PDR=0x3C.
- **RX path and overrun:**
  - Stimulus: PIO_STB with 0x7E, then PIO_STB with 0x42 while full.
  - Required: RX_OVF=1. A read returns DATA_OUT=0x7E with DATA_OE pulse, then RX_FULL=0. A following read returns 0.
- **Simultaneous read and strobe when full:** holding=0x10, PIO_STB with 0x20 in the read cycle -> DATA_OUT=0x10, RX_FULL stays 1, RX_OVF stays 0. The next read returns 0x20.
